// File: rtl/cr_lz77_comp_tile_seq_pkg.sv
// Shared types and helpers for the LZ77 compare-tile frame sequencer.
// Holds the sequencer state encoding and the shift-phase width rule.
package cr_lz77_comp_tile_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREFIX,
        RUN,
        DRAIN,
        CLEAR
    } tile_seq_st_e;

    // A single shift phase still needs a one-bit port.
    function automatic int phase_width(input int shift_mult);
        return (shift_mult > 1) ? $clog2(shift_mult) : 1;
    endfunction

endpackage

// File: rtl/cr_lz77_comp_tile_seq_rpipe.sv
// In-flight tracker for tile results: a RES_LAT-deep valid shift register.
// The empty flag ignores the tail stage, which is being presented this cycle.
module cr_lz77_comp_tile_seq_rpipe #(
    parameter int RES_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_vld,
    output logic out_vld,
    output logic empty
);

    logic [RES_LAT-1:0] pipe_q;
    logic [RES_LAT-1:0] pipe_d;
    logic [RES_LAT-1:0] pending;

    generate
        for (genvar gi = 0; gi < RES_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign pending[gi] = in_vld;
            end else begin : g_body
                assign pending[gi] = pipe_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        pipe_d = flush ? '0 : pending;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign out_vld = pipe_q[RES_LAT-1];
    assign empty   = ~|pending;

endmodule

// File: rtl/cr_lz77_comp_tile_seq.sv
// Frame sequencer for one LZ77 compare tile: accepts prefix/data beats, drives
// registered tile strobes and data, and closes a frame only once results drain.
module cr_lz77_comp_tile_seq
    import cr_lz77_comp_tile_seq_pkg::*;
#(
    parameter int  IN_BYTES   = 8,
    parameter int  SHIFT_MULT = 2,
    parameter int  RES_LAT    = 4,
    localparam int PW         = phase_width(SHIFT_MULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [IN_BYTES*8-1:0] in_data,
    input  logic [IN_BYTES-1:0]   in_data_vld,
    input  logic                  in_prefix,
    input  logic                  in_eof,
    input  logic                  abort,
    input  logic                  res_rdy,
    output logic [IN_BYTES*8-1:0] lz77_tile_data,
    output logic [IN_BYTES-1:0]   lz77_tile_data_vld,
    output logic [IN_BYTES*8-1:0] lz77_tile_prefix_data,
    output logic [IN_BYTES-1:0]   lz77_tile_prefix_data_vld,
    output logic                  prefix_en,
    output logic                  input_en,
    output logic                  shift_en,
    output logic                  me_tile_enable,
    output logic [PW-1:0]         shift_start_phase,
    output logic                  cl_ti_clr_valid,
    output logic                  cl_ti_force_done,
    output logic                  res_vld,
    output logic                  frame_done,
    output logic                  proto_err
);

    tile_seq_st_e          state_q, state_d;
    logic                  me_tile_enable_q, me_tile_enable_d;
    logic                  prefix_en_q, prefix_en_d;
    logic                  input_en_q, input_en_d;
    logic                  shift_en_q, shift_en_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [PW-1:0]         shift_cnt_q, shift_cnt_d;
    logic                  clr_valid_q, clr_valid_d;
    logic                  force_done_q, force_done_d;
    logic                  frame_done_q, frame_done_d;
    logic                  proto_err_q, proto_err_d;
    logic [IN_BYTES*8-1:0] tile_data_q, tile_data_d;
    logic [IN_BYTES-1:0]   tile_data_vld_q, tile_data_vld_d;
    logic [IN_BYTES*8-1:0] prefix_data_q, prefix_data_d;
    logic [IN_BYTES-1:0]   prefix_data_vld_q, prefix_data_vld_d;
    logic                  accept;
    logic                  flush;
    logic                  rpipe_empty;
    logic [PW-1:0]         phase_base;

    function automatic logic [PW-1:0] next_phase(input logic [PW-1:0] p);
        return (p == PW'(SHIFT_MULT - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_rdy = ~rst & res_rdy & ~abort & (state_q inside {IDLE, PREFIX, RUN});
    assign accept = in_vld & in_rdy;

    always_comb begin
        state_d           = state_q;
        me_tile_enable_d  = me_tile_enable_q;
        prefix_en_d       = 1'b0;
        input_en_d        = 1'b0;
        shift_en_d        = 1'b0;
        phase_d           = phase_q;
        shift_cnt_d       = shift_cnt_q;
        clr_valid_d       = 1'b0;
        force_done_d      = 1'b0;
        frame_done_d      = 1'b0;
        proto_err_d       = 1'b0;
        tile_data_d       = tile_data_q;
        tile_data_vld_d   = '0;
        prefix_data_d     = prefix_data_q;
        prefix_data_vld_d = '0;
        flush             = 1'b0;
        // The first beat of a frame always shifts at phase 0.
        phase_base        = (state_q == IDLE) ? '0 : shift_cnt_q;

        case (state_q)
            IDLE, PREFIX, RUN: begin
                if (accept) begin
                    if (state_q == IDLE) begin
                        me_tile_enable_d = 1'b1;
                    end
                    if (in_prefix && state_q == RUN) begin
                        proto_err_d = 1'b1;
                    end else begin
                        shift_en_d  = 1'b1;
                        phase_d     = phase_base;
                        shift_cnt_d = next_phase(phase_base);
                        if (in_prefix) begin
                            prefix_en_d       = 1'b1;
                            prefix_data_d     = in_data;
                            prefix_data_vld_d = in_data_vld;
                        end else begin
                            input_en_d      = 1'b1;
                            tile_data_d     = in_data;
                            tile_data_vld_d = in_data_vld;
                        end
                    end
                    if (in_eof) begin
                        state_d = DRAIN;
                    end else if (!in_prefix) begin
                        state_d = RUN;
                    end else if (state_q == IDLE) begin
                        state_d = PREFIX;
                    end
                end
            end
            DRAIN: begin
                if (rpipe_empty) begin
                    state_d      = CLEAR;
                    clr_valid_d  = 1'b1;
                    frame_done_d = 1'b1;
                end
            end
            CLEAR: begin
                state_d          = IDLE;
                me_tile_enable_d = 1'b0;
                phase_d          = '0;
                shift_cnt_d      = '0;
                // Clear already issued for this frame; only force-done is added.
                if (abort) begin
                    force_done_d = 1'b1;
                    flush        = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && (state_q inside {PREFIX, RUN, DRAIN})) begin
            state_d          = IDLE;
            me_tile_enable_d = 1'b0;
            phase_d          = '0;
            shift_cnt_d      = '0;
            clr_valid_d      = 1'b1;
            force_done_d     = 1'b1;
            frame_done_d     = 1'b1;
            flush            = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            me_tile_enable_q  <= 1'b0;
            prefix_en_q       <= 1'b0;
            input_en_q        <= 1'b0;
            shift_en_q        <= 1'b0;
            phase_q           <= '0;
            shift_cnt_q       <= '0;
            clr_valid_q       <= 1'b0;
            force_done_q      <= 1'b0;
            frame_done_q      <= 1'b0;
            proto_err_q       <= 1'b0;
            tile_data_q       <= '0;
            tile_data_vld_q   <= '0;
            prefix_data_q     <= '0;
            prefix_data_vld_q <= '0;
        end else begin
            state_q           <= state_d;
            me_tile_enable_q  <= me_tile_enable_d;
            prefix_en_q       <= prefix_en_d;
            input_en_q        <= input_en_d;
            shift_en_q        <= shift_en_d;
            phase_q           <= phase_d;
            shift_cnt_q       <= shift_cnt_d;
            clr_valid_q       <= clr_valid_d;
            force_done_q      <= force_done_d;
            frame_done_q      <= frame_done_d;
            proto_err_q       <= proto_err_d;
            tile_data_q       <= tile_data_d;
            tile_data_vld_q   <= tile_data_vld_d;
            prefix_data_q     <= prefix_data_d;
            prefix_data_vld_q <= prefix_data_vld_d;
        end
    end

    cr_lz77_comp_tile_seq_rpipe #(
        .RES_LAT (RES_LAT)
    ) u_rpipe (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .in_vld  (input_en_q),
        .out_vld (res_vld),
        .empty   (rpipe_empty)
    );

    assign lz77_tile_data            = tile_data_q;
    assign lz77_tile_data_vld        = tile_data_vld_q;
    assign lz77_tile_prefix_data     = prefix_data_q;
    assign lz77_tile_prefix_data_vld = prefix_data_vld_q;
    assign prefix_en                 = prefix_en_q;
    assign input_en                  = input_en_q;
    assign shift_en                  = shift_en_q;
    assign me_tile_enable            = me_tile_enable_q;
    assign shift_start_phase         = phase_q;
    assign cl_ti_clr_valid           = clr_valid_q;
    assign cl_ti_force_done          = force_done_q;
    assign frame_done                = frame_done_q;
    assign proto_err                 = proto_err_q;

endmodule
